// File: rtl/hub_reg_multi_if.sv
// rtl/hub_reg_multi_if.sv - register write/read bus between host and the hub register block
interface hub_reg_multi_if;
  logic        reg_wen;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic [15:0] reg_raddr;
  logic [31:0] reg_rdata;

  modport master (output reg_wen, reg_waddr, reg_wdata, reg_raddr, input reg_rdata);
  modport slave  (input reg_wen, reg_waddr, reg_wdata, reg_raddr, output reg_rdata);
endinterface

// File: rtl/hub_reg_multi.sv
// rtl/hub_reg_multi.sv - hub feedback memory, broadcast request latch and active-board index scan
// Optional feature macro: HUB_TIMESTAMP_EN (request timestamp at 0x1804, report latency at 0x1805).
module hub_reg_multi #(
  parameter int unsigned NUM_BOARDS      = 16,
  parameter int unsigned WORDS_PER_BOARD = 32,
  parameter logic [3:0]  HUB_SPACE       = 4'h1
) (
  input  logic           sysclk_i,
  input  logic           reset_n_i,
  hub_reg_multi_if.slave bus,
  output logic [15:0]    sequence_o,
  output logic [15:0]    board_mask_o,
  output logic           hub_reg_wen_o,
  output logic           index_valid_o,
  output logic           all_updated_o
);
  localparam int unsigned BOARD_BITS = $clog2(NUM_BOARDS);
  localparam int unsigned WORD_BITS  = $clog2(WORDS_PER_BOARD);
  localparam int unsigned AW         = BOARD_BITS + WORD_BITS;
  localparam int unsigned MEM_WORDS  = NUM_BOARDS * WORDS_PER_BOARD;
  localparam logic [BOARD_BITS-1:0] LAST_BOARD = BOARD_BITS'(NUM_BOARDS - 1);
  localparam logic [WORD_BITS-1:0]  LAST_WORD  = WORD_BITS'(WORDS_PER_BOARD - 1);
  localparam logic [15:0] MASK_VALID = 16'((32'd1 << NUM_BOARDS) - 32'd1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [BOARD_BITS-1:0]   cur_board_q, cur_board_d;
  logic [BOARD_BITS-1:0]   cur_idx_q, cur_idx_d;
  logic                    first_pass_q, first_pass_d;
  logic [4:0]              num_active_q, num_active_d;
  logic                    idx_we;
  logic [BOARD_BITS-1:0]   read_index_q [NUM_BOARDS];
  logic [15:0]             seq_q, mask_q;
  logic [NUM_BOARDS-1:0]   upd_q, upd_d;
  logic                    hub_wen_q;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             mem_q [MEM_WORDS];

  logic                    wr_mem, wr_req, rd_mem, rd_reg, busy;
  logic [15:0]             new_mask;
  logic [AW-1:0]           wr_phys, rd_phys;
  logic [BOARD_BITS-1:0]   rd_slot;
  logic [63:0]             idx_flat;
  logic [15:0]             upd16;
  logic [NUM_BOARDS-1:0]   mask_nb;
  logic [31:0]             ts_rd, lat_rd;

  // Address decode: write side uses reg_waddr, read side uses reg_raddr
  assign wr_mem = bus.reg_wen && (bus.reg_waddr[15:12] == HUB_SPACE) && (bus.reg_waddr[11:9] == 3'd0)
                  && ({23'd0, bus.reg_waddr[8:0]} < MEM_WORDS);
  assign wr_req = bus.reg_wen && (bus.reg_waddr == {HUB_SPACE, 12'h800});
  assign rd_mem = (bus.reg_raddr[15:12] == HUB_SPACE) && (bus.reg_raddr[11:9] == 3'd0)
                  && ({23'd0, bus.reg_raddr[8:0]} < MEM_WORDS);
  assign rd_reg = (bus.reg_raddr[15:12] == HUB_SPACE) && (bus.reg_raddr[11:3] == 9'h100);

  assign new_mask = bus.reg_wdata[15:0] & MASK_VALID;
  assign wr_phys  = bus.reg_waddr[AW-1:0];
  assign rd_slot  = bus.reg_raddr[AW-1:WORD_BITS];
  assign rd_phys  = {read_index_q[rd_slot], bus.reg_raddr[WORD_BITS-1:0]};

  always_ff @(posedge sysclk_i) begin
    if (wr_mem) mem_q[wr_phys] <= bus.reg_wdata;
  end

  // Scan: walk boards cyclically, appending every masked board until all slots are filled
  always_comb begin
    state_d      = state_q;
    cur_board_d  = cur_board_q;
    cur_idx_d    = cur_idx_q;
    first_pass_d = first_pass_q;
    num_active_d = num_active_q;
    idx_we       = 1'b0;
    if (wr_req) begin
      state_d      = (new_mask != 16'd0) ? SCAN : IDLE;
      cur_board_d  = '0;
      cur_idx_d    = '0;
      first_pass_d = 1'b1;
      num_active_d = '0;
    end else if (state_q == SCAN) begin
      cur_board_d = cur_board_q + 1'b1;
      if (cur_board_q == LAST_BOARD) first_pass_d = 1'b0;
      if (mask_q[cur_board_q]) begin
        idx_we = 1'b1;
        if (first_pass_q) num_active_d = num_active_q + 5'd1;
        if (cur_idx_q == LAST_BOARD) state_d = DONE;
        else cur_idx_d = cur_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    upd_d = upd_q;
    if (wr_req) upd_d = '0;
    else if (wr_mem && (wr_phys[WORD_BITS-1:0] == LAST_WORD)) upd_d[wr_phys[AW-1:WORD_BITS]] = 1'b1;
  end

  always_comb begin
    idx_flat = '0;
    for (int i = 0; i < NUM_BOARDS; i++) idx_flat[63-4*i -: 4] = 4'(read_index_q[i]);
  end

  assign upd16   = 16'(upd_q);
  assign mask_nb = mask_q[NUM_BOARDS-1:0];
  assign busy    = (state_q == SCAN);

  always_comb begin
    rdata_d = '0;
    if (rd_mem) begin
      rdata_d = mem_q[rd_phys];
    end else if (rd_reg) begin
      case (bus.reg_raddr[2:0])
        3'd0:    rdata_d = {seq_q, mask_q};
        3'd1:    rdata_d = idx_flat[63:32];
        3'd2:    rdata_d = idx_flat[31:0];
        3'd3:    rdata_d = {index_valid_o, busy, 9'd0, num_active_q, upd16};
        3'd4:    rdata_d = ts_rd;
        3'd5:    rdata_d = lat_rd;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      cur_board_q  <= '0;
      cur_idx_q    <= '0;
      first_pass_q <= 1'b0;
      num_active_q <= '0;
      seq_q        <= '0;
      mask_q       <= '0;
      upd_q        <= '0;
      hub_wen_q    <= 1'b0;
      rdata_q      <= '0;
      for (int i = 0; i < NUM_BOARDS; i++) read_index_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cur_board_q  <= cur_board_d;
      cur_idx_q    <= cur_idx_d;
      first_pass_q <= first_pass_d;
      num_active_q <= num_active_d;
      upd_q        <= upd_d;
      hub_wen_q    <= wr_req;
      rdata_q      <= rdata_d;
      if (wr_req) begin
        seq_q  <= bus.reg_wdata[31:16];
        mask_q <= new_mask;
      end
      if (idx_we) read_index_q[cur_idx_q] <= cur_board_q;
    end
  end

`ifdef HUB_TIMESTAMP_EN
  logic [31:0] tick_q, ts_req_q, lat_q;
  logic        lat_run_q;

  // Latency counts cycles after the request edge until all_updated is first seen high
  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tick_q    <= '0;
      ts_req_q  <= '0;
      lat_q     <= '0;
      lat_run_q <= 1'b0;
    end else begin
      tick_q <= tick_q + 32'd1;
      if (wr_req) begin
        ts_req_q  <= tick_q;
        lat_q     <= '0;
        lat_run_q <= 1'b1;
      end else if (lat_run_q) begin
        if (all_updated_o) lat_run_q <= 1'b0;
        else if (lat_q != 32'hFFFF_FFFF) lat_q <= lat_q + 32'd1;
      end
    end
  end

  assign ts_rd  = ts_req_q;
  assign lat_rd = lat_q;
`else
  assign ts_rd  = '0;
  assign lat_rd = '0;
`endif

  assign bus.reg_rdata = rdata_q;
  assign sequence_o    = seq_q;
  assign board_mask_o  = mask_q;
  assign hub_reg_wen_o = hub_wen_q;
  assign index_valid_o = (state_q == DONE);
  assign all_updated_o = index_valid_o && ((upd_q & mask_nb) == mask_nb) && (mask_nb != '0);
endmodule

// File: tb/tb_hub_reg_multi.sv
// tb/tb_hub_reg_multi.sv - self-checking bench for hub_reg_multi with table vectors and a random reference model
module tb_hub_reg_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hub_reg_multi_if bus();
  logic [15:0] seq_w, mask_w;
  logic        hwen, ivalid, allupd;

  hub_reg_multi dut (
    .sysclk_i(clk), .reset_n_i(rst_n), .bus(bus),
    .sequence_o(seq_w), .board_mask_o(mask_w), .hub_reg_wen_o(hwen),
    .index_valid_o(ivalid), .all_updated_o(allupd)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_m [512];
  logic [3:0]  idx_m [16];
  int          n_m;
  logic [15:0] mask_m, seq_m, upd_m;

  typedef struct {
    logic [31:0] req;
    logic [31:0] e1801;
    logic [31:0] e1802;
    logic [4:0]  enum_act;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_request(input logic [31:0] d);
    int act[$];
    seq_m  = d[31:16];
    mask_m = d[15:0];
    upd_m  = '0;
    for (int b = 0; b < 16; b++) if (mask_m[b]) act.push_back(b);
    n_m = act.size();
    if (n_m != 0)
      for (int i = 0; i < 16; i++) idx_m[i] = 4'(act[i % n_m]);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    bus.reg_wen   = 1'b1;
    bus.reg_waddr = a;
    bus.reg_wdata = d;
    tick();
    bus.reg_wen = 1'b0;
    if (a[15:12] == 4'h1 && a[11:9] == 3'd0) begin
      mem_m[a[8:0]] = d;
      if (a[4:0] == 5'd31) upd_m[a[8:5]] = 1'b1;
    end
    if (a == 16'h1800) model_request(d);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    bus.reg_raddr = a;
    tick();
    d = bus.reg_rdata;
  endtask

  function automatic logic [31:0] pack(input int base);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[31-4*i -: 4] = idx_m[base+i];
    return r;
  endfunction

  function automatic logic [31:0] mem_exp(input logic [15:0] la);
    logic [8:0] pa;
    pa = {idx_m[la[8:5]], la[4:0]};
    return mem_m[pa];
  endfunction

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!ivalid && n < 400) begin
      tick();
      n++;
    end
    chk(name, {31'd0, ivalid}, 32'd1);
  endtask

  logic [31:0] r;
  logic [15:0] la;
  logic [8:0]  pa9;
  int          c0;

  initial begin
    bus.reg_wen = 1'b0; bus.reg_waddr = '0; bus.reg_wdata = '0; bus.reg_raddr = 16'h1800;
    mask_m = '0; seq_m = '0; upd_m = '0; n_m = 0;
    for (int i = 0; i < 16; i++) idx_m[i] = '0;

    vecs[0] = '{32'h0001_0001, 32'h0000_0000, 32'h0000_0000, 5'd1};
    vecs[1] = '{32'h0002_8000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1};
    vecs[2] = '{32'h0003_FFFF, 32'h0123_4567, 32'h89AB_CDEF, 5'd16};
    vecs[3] = '{32'h0004_0003, 32'h0101_0101, 32'h0101_0101, 5'd2};
    vecs[4] = '{32'h1234_1248, 32'h369C_369C, 32'h369C_369C, 5'd4};
    vecs[5] = '{32'h0005_00A1, 32'h0570_5705, 32'h7057_0570, 5'd3};

    repeat (3) tick();
    chk("rst_rdata", bus.reg_rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      rd(16'h1800 + 16'(a), r);
      chk($sformatf("rst_reg%0d", a), r, 32'd0);
    end
    rd(16'h1806, r);
    chk("rst_reg6", r, 32'd0);
    chk("rst_flags", {29'd0, ivalid, allupd, hwen}, 32'd0);
    chk("rst_outs", {seq_w, mask_w}, 32'd0);

    for (int p = 0; p < 512; p++) wr(16'h1000 + 16'(p), $urandom);

    for (int v = 0; v < 6; v++) begin
      wr(16'h1800, vecs[v].req);
      chk($sformatf("v%0d_wen_pulse", v), {31'd0, hwen}, 32'd1);
      chk($sformatf("v%0d_valid_drop", v), {31'd0, ivalid}, 32'd0);
      tick();
      chk($sformatf("v%0d_wen_low", v), {31'd0, hwen}, 32'd0);
      wait_done($sformatf("v%0d_done", v));
      rd(16'h1800, r);
      chk($sformatf("v%0d_req", v), r, vecs[v].req);
      chk($sformatf("v%0d_outs", v), {seq_w, mask_w}, vecs[v].req);
      rd(16'h1801, r);
      chk($sformatf("v%0d_1801", v), r, vecs[v].e1801);
      rd(16'h1802, r);
      chk($sformatf("v%0d_1802", v), r, vecs[v].e1802);
      rd(16'h1803, r);
      chk($sformatf("v%0d_num", v), {27'd0, r[20:16]}, {27'd0, vecs[v].enum_act});
    end

    wr(16'h10BF, 32'hDEAD_BEEF);
    rd(16'h1020, r);
    chk("slot1_word0", r, mem_m[9'h0A0]);
    rd(16'h103F, r);
    chk("slot1_word31", r, 32'hDEAD_BEEF);
    rd(16'h1803, r);
    chk("status_b5", r, 32'h8003_0020);

    chk("allupd_partial0", {31'd0, allupd}, 32'd0);
    wr(16'h101F, 32'h1111_0000);
    chk("allupd_partial1", {31'd0, allupd}, 32'd0);
    wr(16'h10FF, 32'h7777_0000);
    chk("allupd_set", {31'd0, allupd}, 32'd1);
    wr(16'h1800, 32'h0006_00A1);
    chk("restart_valid", {31'd0, ivalid}, 32'd0);
    chk("restart_allupd", {31'd0, allupd}, 32'd0);
    rd(16'h1803, r);
    chk("restart_upd", {16'd0, r[15:0]}, 32'd0);
    wait_done("restart_done");

    wr(16'h1801, 32'h1234_5678);
    rd(16'h1801, r);
    chk("ro_1801", r, 32'h0570_5705);
    wr(16'h1200, 32'hCAFE_F00D);
    wr(16'h2000, 32'hBAD0_BAD0);
    rd(16'h1000, r);
    chk("decode_ignore", r, mem_exp(16'h1000));

    wr(16'h1800, 32'h0008_0001);
    tick();
    wr(16'h1800, 32'h0009_8000);
    wait_done("m8000_done");
    rd(16'h1801, r);
    chk("m8000_1801", r, 32'hFFFF_FFFF);
    rd(16'h1802, r);
    chk("m8000_1802", r, 32'hFFFF_FFFF);
    rd(16'h1803, r);
    chk("m8000_num", {27'd0, r[20:16]}, 32'd1);
    wr(16'h1800, 32'h000A_0000);
    repeat (5) tick();
    chk("m0_valid", {31'd0, ivalid}, 32'd0);
    rd(16'h1803, r);
    chk("m0_status", r, 32'd0);

    for (int it = 0; it < 6; it++) begin
      wr(16'h1800, {16'($urandom), 16'($urandom_range(1, 65535))});
      wait_done($sformatf("rnd%0d_done", it));
      rd(16'h1801, r);
      chk($sformatf("rnd%0d_1801", it), r, pack(0));
      rd(16'h1802, r);
      chk($sformatf("rnd%0d_1802", it), r, pack(8));
      rd(16'h1803, r);
      chk($sformatf("rnd%0d_num", it), {27'd0, r[20:16]}, 32'(n_m));
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 1) == 0) begin
          pa9 = 9'($urandom_range(0, 511));
          if ($urandom_range(0, 2) == 0) pa9[4:0] = 5'd31;
          wr(16'h1000 | 16'(pa9), $urandom);
        end else begin
          la = 16'h1000 + 16'($urandom_range(0, 511));
          rd(la, r);
          chk($sformatf("rnd%0d_rd_%h", it, la), r, mem_exp(la));
        end
      end
      rd(16'h1803, r);
      chk($sformatf("rnd%0d_upd", it), {16'd0, r[15:0]}, {16'd0, upd_m});
      chk($sformatf("rnd%0d_allupd", it), {31'd0, allupd},
          {31'd0, (mask_m != 0) && ((upd_m & mask_m) == mask_m)});
    end

    wr(16'h1800, 32'h000B_FFFF);
    c0 = cyc;
    wait_done("ts_done");
    for (int b = 0; b < 15; b++) wr(16'h1000 + 16'(b * 32 + 31), 32'(b));
    chk("ts_allupd_pre", {31'd0, allupd}, 32'd0);
    while (cyc < c0 + 99) tick();
    wr(16'h11FF, 32'h0000_000F);
    chk("ts_allupd", {31'd0, allupd}, 32'd1);
    repeat (3) tick();
    rd(16'h1805, r);
`ifdef HUB_TIMESTAMP_EN
    chk("ts_latency_range", {31'd0, (r >= 32'd99) && (r <= 32'd101)}, 32'd1);
`else
    chk("ts_latency_off", r, 32'd0);
    rd(16'h1804, r);
    chk("ts_stamp_off", r, 32'd0);
`endif

    wr(16'h1800, 32'h000C_8000);
    repeat (20) tick();
    rd(16'h1803, r);
    chk("midscan_busy", {30'd0, r[31:30]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midscan_rst_outs", {seq_w, mask_w}, 32'd0);
    chk("midscan_rst_valid", {31'd0, ivalid}, 32'd0);
    tick();
    rst_n = 1'b1;
    rd(16'h1801, r);
    chk("midscan_1801", r, 32'd0);
    rd(16'h1802, r);
    chk("midscan_1802", r, 32'd0);
    rd(16'h1803, r);
    chk("midscan_1803", r, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
